loop_completion_tracker: RTL and testbench
==========================================

LOOP_COMPLETION_TRACKER -- requirements
Module: loop_completion_tracker

Interface
REQ-001 SHALL have parameter N, default 2: iterations per run (N >= 1).
REQ-002 SHALL have parameter LATENCY, default 1: pipeline depth in cycles from issue to completion (LATENCY >= 1).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: begin a new run; also aborts any run in progress.
REQ-006 SHALL have port issue, input, 1: one iteration entered the pipeline this cycle (driven by the issue-side schedule generator).
REQ-007 SHALL have port valid_out, output, 1: one iteration completes this cycle.
REQ-008 SHALL have port iter_index, output, 32: index of the completing iteration, 0..N-1; held at its last value when valid_out is low.
REQ-009 SHALL have port last, output, 1: valid_out high and iter_index == N-1.
REQ-010 SHALL have port in_flight, output, 32: accepted issues minus completions.
REQ-011 SHALL have port done, output, 1: level; all N iterations of the current run completed.
REQ-012 SHALL have port err, output, 1: sticky protocol-violation flag.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 SHALL move to RUN on start from any state and clear the issue count, completion count, in_flight, err, and delay line.
REQ-015 SHALL accept an issue only in RUN or in the cycle start is high; an issue coinciding with start SHALL be iteration 0 of the new run.
REQ-016 SHALL, when accepted issues reach N, move to DRAIN the next cycle.
REQ-017 SHALL assert valid_out exactly LATENCY cycles after each accepted issue, one cycle per issue, and SHALL emit indices in strictly increasing order from 0.
REQ-018 SHALL enter DONE in the cycle after the valid_out with last high, and SHALL hold done high until start or rst.
REQ-019 SHALL ignore an issue in IDLE, DRAIN, or DONE (not counted, no valid_out) and set err.
REQ-020 SHALL let start abort a run so that no valid_out from pre-abort issues ever appears.
REQ-021 SHALL update in_flight as a registered value: +1 per accepted issue, -1 per completion, net 0 when both occur in the same cycle; it SHALL never underflow.
REQ-022 SHALL use 32-bit unsigned counters; N <= 2^32-1, and no wrap occurs within a run.
REQ-023 SHALL accept back-to-back issues (II = 1) with no bubbles.

Reset
REQ-024 SHALL, while rst is high, force state IDLE, clear the delay line, and drive valid_out=0, iter_index=0, last=0, in_flight=0, done=0, err=0.
REQ-025 SHALL give rst priority over start and issue; rst mid-run SHALL discard all in-flight iterations.

Structure
REQ-026 SHALL place the counter-width constant (32) and the state encodings in a shared package/include used by the loop-control builtins.
REQ-027 SHALL implement the LATENCY-deep 1-bit shift register, with synchronous flush, as sub-module issue_delay_line.

Verification
REQ-028 SHALL cover: N=4, LATENCY=3, start+issue at cycles 0,1,2,3 -> valid_out at cycles 3..6 with iter_index 0..3, last at 6, done from cycle 7, in_flight peak 3.
REQ-029 SHALL cover: N=3, LATENCY=2, issues at cycles 0,2,4 (II=2) -> valid_out at 2,4,6, in_flight never exceeds 1, done at 7.
REQ-030 SHALL cover: N=4, LATENCY=3, start again at cycle 2 of a run -> no valid_out for the old run's issues, indices restart at 0, err=0.
REQ-031 SHALL cover: issue in IDLE, then a 5th issue with N=4 -> err=1, no extra valid_out, in_flight unaffected.
REQ-032 SHALL cover: rst at cycle 4 of the REQ-028 run -> all outputs 0 at cycle 5, no valid_out afterwards.
REQ-033 SHALL cover: start+issue while in DONE -> done low the next cycle, iteration 0 completes LATENCY cycles later.

Source files
------------

// File: rtl/loop_completion_tracker_pkg.sv
// Shared types for the loop completion tracker.
// Counter width and FSM state encodings.
package loop_completion_tracker_pkg;

    localparam int unsigned CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/loop_completion_tracker_if.sv
// Handshake bundle between schedule generator and tracker.
// master: drives start/issue; slave: the tracker itself.
interface loop_completion_tracker_if;
    import loop_completion_tracker_pkg::*;

    logic start;
    logic issue;
    logic valid_out;
    cnt_t iter_index;
    logic last;
    cnt_t in_flight;
    logic done;
    logic err;

    modport master (
        output start,
        output issue,
        input  valid_out,
        input  iter_index,
        input  last,
        input  in_flight,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  issue,
        output valid_out,
        output iter_index,
        output last,
        output in_flight,
        output done,
        output err
    );

endinterface

// File: rtl/loop_completion_tracker_issue_delay_line.sv
// LATENCY-deep 1-bit shift register with synchronous flush.
// Ports: clk, rst, flush (clears old stages), in_bit, out_bit.
module issue_delay_line #(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_bit,
    output logic out_bit
);

    logic [LATENCY-1:0] sr_q;
    logic [LATENCY-1:0] sr_d;

    // A flush drops every older stage but still loads in_bit,
    // so an issue in the flush cycle survives.
    always_comb begin
        sr_d    = flush ? '0 : (sr_q << 1);
        sr_d[0] = in_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_bit = sr_q[LATENCY-1];

endmodule

// File: rtl/loop_completion_tracker.sv
// Tracks issue/completion of an N-iteration loop run.
// Ports: clk, rst (sync, active-high), bus (slave: start/issue in, status out).
module loop_completion_tracker
    import loop_completion_tracker_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    loop_completion_tracker_if.slave    bus
);

    localparam cnt_t N_C      = CNT_W'(N);
    localparam cnt_t LAST_IDX = CNT_W'(N - 1);
    localparam cnt_t ONE      = CNT_W'(1);

    state_e state_q;
    state_e state_d;
    cnt_t   issue_cnt_q;
    cnt_t   issue_cnt_d;
    cnt_t   comp_cnt_q;
    cnt_t   comp_cnt_d;
    cnt_t   in_flight_q;
    cnt_t   in_flight_d;
    cnt_t   idx_hold_q;
    cnt_t   idx_hold_d;
    logic   err_q;
    logic   err_d;

    logic   accept;
    logic   complete;
    logic   dl_out;

    // An issue coinciding with start belongs to the new run.
    assign accept = bus.issue && (bus.start || state_q == ST_RUN);

    // Completions that emerge in a start cycle belong to the
    // aborted run and are suppressed.
    assign complete = dl_out && !bus.start;

    issue_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.start),
        .in_bit  (accept),
        .out_bit (dl_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = (bus.issue && N_C == ONE) ? ST_DRAIN : ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (accept && (issue_cnt_q + ONE) == N_C) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (complete && comp_cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        comp_cnt_d  = comp_cnt_q;
        in_flight_d = in_flight_q;
        idx_hold_d  = idx_hold_q;
        err_d       = err_q;

        if (bus.start) begin
            issue_cnt_d = bus.issue ? ONE : '0;
            comp_cnt_d  = '0;
            in_flight_d = bus.issue ? ONE : '0;
            err_d       = 1'b0;
        end else begin
            if (accept) begin
                issue_cnt_d = issue_cnt_q + ONE;
            end
            if (complete) begin
                comp_cnt_d = comp_cnt_q + ONE;
                idx_hold_d = comp_cnt_q;
            end
            // Issue + completion in one cycle nets to zero.
            if (accept && !complete) begin
                in_flight_d = in_flight_q + ONE;
            end else if (!accept && complete && in_flight_q != '0) begin
                in_flight_d = in_flight_q - ONE;
            end
            if (bus.issue && !accept) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            comp_cnt_q  <= '0;
            in_flight_q <= '0;
            idx_hold_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            comp_cnt_q  <= comp_cnt_d;
            in_flight_q <= in_flight_d;
            idx_hold_q  <= idx_hold_d;
            err_q       <= err_d;
        end
    end

    // Outputs read as zero for the whole time rst is high.
    always_comb begin
        bus.valid_out  = complete && !rst;
        bus.iter_index = rst ? '0 : (complete ? comp_cnt_q : idx_hold_q);
        bus.last       = complete && !rst && comp_cnt_q == LAST_IDX;
        bus.in_flight  = rst ? '0 : in_flight_q;
        bus.done       = !rst && state_q == ST_DONE;
        bus.err        = !rst && err_q;
    end

endmodule

// File: tb/tb_loop_completion_tracker.sv
// Bench for loop_completion_tracker: scoreboarded completions,
// two instances (N=4/LAT=3 and N=3/LAT=2).
module tb_loop_completion_tracker;

    localparam int NA = 4;
    localparam int LA = 3;
    localparam int NB = 3;
    localparam int LB = 2;

    typedef struct {
        int due;
        int idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ma;
    exp_t mb;

    loop_completion_tracker_if a_if ();
    loop_completion_tracker_if b_if ();

    loop_completion_tracker #(.N(NA), .LATENCY(LA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    loop_completion_tracker #(.N(NB), .LATENCY(LB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitor, instance A
    always @(negedge clk) begin
        if (a_if.valid_out === 1'b1) begin
            n_checks++;
            if (sb_a.size() == 0) begin
                n_fails++;
                $display("FAIL a_unexpected_valid cyc=%0d idx=%0d required no valid_out",
                         cyc, a_if.iter_index);
            end else begin
                ma = sb_a.pop_front();
                if (ma.due !== cyc || a_if.iter_index !== 32'(ma.idx)
                    || a_if.last !== (ma.idx == NA - 1)) begin
                    n_fails++;
                    $display("FAIL a_completion cyc=%0d idx=%0d last=%b required cyc=%0d idx=%0d last=%b",
                             cyc, a_if.iter_index, a_if.last,
                             ma.due, ma.idx, ma.idx == NA - 1);
                end
            end
        end else if (sb_a.size() > 0 && sb_a[0].due < cyc) begin
            n_checks++;
            n_fails++;
            ma = sb_a.pop_front();
            $display("FAIL a_missed_valid cyc=%0d valid_out=0 required idx=%0d at cyc=%0d",
                     cyc, ma.idx, ma.due);
        end
    end

    // Completion monitor, instance B
    always @(negedge clk) begin
        if (b_if.valid_out === 1'b1) begin
            n_checks++;
            if (sb_b.size() == 0) begin
                n_fails++;
                $display("FAIL b_unexpected_valid cyc=%0d idx=%0d required no valid_out",
                         cyc, b_if.iter_index);
            end else begin
                mb = sb_b.pop_front();
                if (mb.due !== cyc || b_if.iter_index !== 32'(mb.idx)
                    || b_if.last !== (mb.idx == NB - 1)) begin
                    n_fails++;
                    $display("FAIL b_completion cyc=%0d idx=%0d last=%b required cyc=%0d idx=%0d last=%b",
                             cyc, b_if.iter_index, b_if.last,
                             mb.due, mb.idx, mb.idx == NB - 1);
                end
            end
        end else if (sb_b.size() > 0 && sb_b[0].due < cyc) begin
            n_checks++;
            n_fails++;
            mb = sb_b.pop_front();
            $display("FAIL b_missed_valid cyc=%0d valid_out=0 required idx=%0d at cyc=%0d",
                     cyc, mb.idx, mb.due);
        end
    end

    task automatic step_a(input logic r, input logic s, input logic i,
                          input logic ea, input int idx);
        @(posedge clk);
        #1;
        rst = r;
        a_if.start = s;
        a_if.issue = i;
        if (r) sb_b.delete();
        if (r || s) sb_a.delete();
        if (ea) sb_a.push_back('{cyc + LA, idx});
    endtask

    task automatic step_b(input logic s, input logic i,
                          input logic ea, input int idx);
        @(posedge clk);
        #1;
        b_if.start = s;
        b_if.issue = i;
        if (s) sb_b.delete();
        if (ea) sb_b.push_back('{cyc + LB, idx});
    endtask

    task automatic test_reset();
        step_a(1, 0, 0, 0, 0);
        step_a(1, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (a_if.valid_out !== 1'b0 || a_if.last !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_valid_last got %b/%b required 0/0",
                     a_if.valid_out, a_if.last);
        end
        n_checks++;
        if (a_if.iter_index !== 32'd0 || a_if.in_flight !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_index_inflight got %0d/%0d required 0/0",
                     a_if.iter_index, a_if.in_flight);
        end
        n_checks++;
        if (a_if.done !== 1'b0 || a_if.err !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_done_err got %b/%b required 0/0",
                     a_if.done, a_if.err);
        end
        step_a(0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        int exp_if[10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            step_a(0, k == 0, k < 4, k < 4, k);
            @(negedge clk);
            n_checks++;
            if (a_if.in_flight !== 32'(exp_if[k]) || a_if.done !== (k >= 7)) begin
                n_fails++;
                $display("FAIL basic_k%0d in_flight=%0d done=%b required %0d/%b",
                         k, a_if.in_flight, a_if.done, exp_if[k], k >= 7);
            end
        end
        n_checks++;
        if (sb_a.size() != 0) begin
            n_fails++;
            $display("FAIL basic_drain pending=%0d required 0", sb_a.size());
        end
    endtask

    task automatic test_restart_done();
        for (int k = 0; k < 10; k++) begin
            step_a(0, k == 0, k < 4, k < 4, k);
            @(negedge clk);
            n_checks++;
            if (a_if.done !== (k == 0 || k >= 7)) begin
                n_fails++;
                $display("FAIL restart_done_k%0d done=%b required %b",
                         k, a_if.done, k == 0 || k >= 7);
            end
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 12; k++) begin
            if (k < 2) step_a(0, k == 0, 1, 1, k);
            else if (k < 6) step_a(0, k == 2, 1, 1, k - 2);
            else step_a(0, 0, 0, 0, 0);
            @(negedge clk);
            if (k == 3 || k == 11) begin
                n_checks++;
                if (a_if.err !== 1'b0) begin
                    n_fails++;
                    $display("FAIL abort_err_k%0d err=%b required 0", k, a_if.err);
                end
            end
        end
        n_checks++;
        if (a_if.done !== 1'b1 || sb_a.size() != 0) begin
            n_fails++;
            $display("FAIL abort_end done=%b pending=%0d required 1/0",
                     a_if.done, sb_a.size());
        end
    endtask

    task automatic test_err();
        step_a(1, 0, 0, 0, 0);
        for (int k = 0; k < 13; k++) begin
            if (k == 0) step_a(0, 0, 1, 0, 0);
            else if (k == 1) step_a(0, 1, 0, 0, 0);
            else if (k < 6) step_a(0, 0, 1, 1, k - 2);
            else if (k == 6) step_a(0, 0, 1, 0, 0);
            else step_a(0, 0, 0, 0, 0);
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (a_if.err !== 1'b1 || a_if.in_flight !== 32'd0) begin
                    n_fails++;
                    $display("FAIL err_idle err=%b in_flight=%0d required 1/0",
                             a_if.err, a_if.in_flight);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (a_if.err !== 1'b0) begin
                    n_fails++;
                    $display("FAIL err_clear err=%b required 0", a_if.err);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (a_if.err !== 1'b1 || a_if.in_flight !== 32'd2) begin
                    n_fails++;
                    $display("FAIL err_fifth err=%b in_flight=%0d required 1/2",
                             a_if.err, a_if.in_flight);
                end
            end
        end
        n_checks++;
        if (a_if.done !== 1'b1 || sb_a.size() != 0) begin
            n_fails++;
            $display("FAIL err_end done=%b pending=%0d required 1/0",
                     a_if.done, sb_a.size());
        end
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 11; k++) begin
            if (k < 4) step_a(0, k == 0, 1, 1, k);
            else if (k == 4) step_a(1, 0, 0, 0, 0);
            else step_a(0, 0, 0, 0, 0);
            @(negedge clk);
            if (k == 5) begin
                n_checks++;
                if (a_if.valid_out !== 1'b0 || a_if.iter_index !== 32'd0
                    || a_if.last !== 1'b0) begin
                    n_fails++;
                    $display("FAIL rst_mid_out valid=%b idx=%0d last=%b required 0/0/0",
                             a_if.valid_out, a_if.iter_index, a_if.last);
                end
                n_checks++;
                if (a_if.in_flight !== 32'd0 || a_if.done !== 1'b0
                    || a_if.err !== 1'b0) begin
                    n_fails++;
                    $display("FAIL rst_mid_state in_flight=%0d done=%b err=%b required 0/0/0",
                             a_if.in_flight, a_if.done, a_if.err);
                end
            end
        end
    endtask

    task automatic test_ii2();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) step_b(1, 1, 1, 0);
            else if (k == 2 || k == 4) step_b(0, 1, 1, k / 2);
            else step_b(0, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if (b_if.in_flight > 32'd1 || b_if.done !== (k >= 7)) begin
                n_fails++;
                $display("FAIL ii2_k%0d in_flight=%0d done=%b required <=1/%b",
                         k, b_if.in_flight, b_if.done, k >= 7);
            end
        end
        n_checks++;
        if (sb_b.size() != 0) begin
            n_fails++;
            $display("FAIL ii2_drain pending=%0d required 0", sb_b.size());
        end
    endtask

    initial begin
        a_if.start = 1'b0;
        a_if.issue = 1'b0;
        b_if.start = 1'b0;
        b_if.issue = 1'b0;
        test_reset();
        test_basic();
        test_restart_done();
        test_abort();
        test_err();
        test_rst_mid();
        test_ii2();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
